sc_stream_decoder: RTL

- Converts a stochastic bitstream into a binary value; it is the receive end for the 8-bit SNG that feeds the compare-and-swap sorting stages.
- Counts the ones seen over one full stream period of 2^SNG_WIDTH valid bits, then returns the count as a binary value.
- Sits at the output of a DSC datapath, for example behind a sorter lane, and returns results to the binary domain.

---
 rtl/sc_stream_decoder.sv | 92 +++++++++
 1 files changed

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts ones over a 2^SNG_WIDTH-bit stochastic stream.
// Define SC_STREAM_DECODER_BIPOLAR_EN for a two's-complement bipolar value.
module sc_stream_decoder #(
    parameter int SNG_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               busy,
    output logic               done,
    output logic [SNG_WIDTH:0] value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SNG_WIDTH:0] ZERO   = '0;
    localparam logic [SNG_WIDTH:0] ONE    = {{SNG_WIDTH{1'b0}}, 1'b1};
    localparam logic [SNG_WIDTH:0] PERIOD = {1'b1, {SNG_WIDTH{1'b0}}};
`ifdef SC_STREAM_DECODER_BIPOLAR_EN
    localparam logic [SNG_WIDTH:0] HALF   = PERIOD >> 1;
`endif

    state_t             state;
    logic [SNG_WIDTH:0] ones_cnt;
    logic [SNG_WIDTH:0] bit_cnt;
    logic [SNG_WIDTH:0] ones_next;
    logic [SNG_WIDTH:0] bit_next;
    logic [SNG_WIDTH:0] result;

    // Next counts include the bit presented this cycle.
    always_comb begin
        ones_next = ones_cnt + {{SNG_WIDTH{1'b0}}, bit_in};
        bit_next  = bit_cnt + ONE;
`ifdef SC_STREAM_DECODER_BIPOLAR_EN
        result    = ones_next - HALF;
`else
        result    = ones_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            value    <= ZERO;
            ones_cnt <= ZERO;
            bit_cnt  <= ZERO;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= COUNT;
                        busy     <= 1'b1;
                        ones_cnt <= ZERO;
                        bit_cnt  <= ZERO;
                    end
                end
                COUNT: begin
                    if (bit_valid) begin
                        ones_cnt <= ones_next;
                        bit_cnt  <= bit_next;
                        if (bit_next == PERIOD) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            value <= result;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
